// File: rtl/input_buffer_rc.sv
// rtl/input_buffer_rc.sv - router input FIFO that stores an XY route code alongside each flit
module input_buffer_rc #(
    parameter int DEPTH = 4,
    parameter int X_ID  = 0,
    parameter int Y_ID  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [15:0] q_o,
    output logic        valid_o,
    output logic [2:0]  route_o,
    input  logic        pop_req_i,
    output logic [4:0]  count_o,
    output logic        ovf_err_o,
    output logic        unf_err_o
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] ROUTE_N = 3'd0;
    localparam logic [2:0] ROUTE_S = 3'd1;
    localparam logic [2:0] ROUTE_E = 3'd2;
    localparam logic [2:0] ROUTE_W = 3'd3;
    localparam logic [2:0] ROUTE_L = 3'd4;

    logic [18:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic          r_ovf_err;
    logic          r_unf_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_dest_x;
    logic [1:0]    w_dest_y;
    logic [2:0]    w_route;

    assign w_full   = (r_count == 5'(DEPTH));
    assign w_empty  = (r_count == 5'd0);
    assign w_push   = valid_i && !w_full;
    assign w_pop    = pop_req_i && !w_empty;
    assign w_dest_x = data_i[15:14];
    assign w_dest_y = data_i[13:12];

    // Dimension-ordered routing: resolve X first, then Y, then deliver locally.
    always_comb begin
        w_route = ROUTE_L;
        if (w_dest_x > 2'(X_ID))
            w_route = ROUTE_E;
        else if (w_dest_x < 2'(X_ID))
            w_route = ROUTE_W;
        else if (w_dest_y > 2'(Y_ID))
            w_route = ROUTE_N;
        else if (w_dest_y < 2'(Y_ID))
            w_route = ROUTE_S;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_route, data_i};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + 5'd1;
            else if (w_pop && !w_push)
                r_count <= r_count - 5'd1;
            // A push while full is dropped even if a pop frees a slot this same cycle.
            if (valid_i && w_full)
                r_ovf_err <= 1'b1;
            if (pop_req_i && w_empty)
                r_unf_err <= 1'b1;
        end
    end

    assign q_o       = r_mem[r_rd_ptr][15:0];
    assign route_o   = r_mem[r_rd_ptr][18:16];
    assign valid_o   = !w_empty;
    assign ready_o   = !w_full;
    assign count_o   = r_count;
    assign ovf_err_o = r_ovf_err;
    assign unf_err_o = r_unf_err;
endmodule

// File: tb/tb_input_buffer_rc.sv
// tb/tb_input_buffer_rc.sv - randomized and directed bench for input_buffer_rc
module tb_input_buffer_rc;
    localparam int DEPTH = 4;
    localparam int XI    = 1;
    localparam int YI    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        pop_req_i = 1'b0;
    logic        ready_o;
    logic [15:0] q_o;
    logic        valid_o;
    logic [2:0]  route_o;
    logic [4:0]  count_o;
    logic        ovf_err_o;
    logic        unf_err_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] mq[$];
    bit          m_ovf;
    bit          m_unf;

    input_buffer_rc #(.DEPTH(DEPTH), .X_ID(XI), .Y_ID(YI)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .q_o(q_o), .valid_o(valid_o), .route_o(route_o),
        .pop_req_i(pop_req_i), .count_o(count_o),
        .ovf_err_o(ovf_err_o), .unf_err_o(unf_err_o)
    );

    always #5 clk = ~clk;

    function automatic int ref_route(input logic [15:0] d);
        int dx = int'(d[15:14]);
        int dy = int'(d[13:12]);
        if (dx > XI) return 2;
        if (dx < XI) return 3;
        if (dy > YI) return 0;
        if (dy < YI) return 1;
        return 4;
    endfunction

    // One clock of stimulus; the model updates from its own state, then outputs settle 1ns after the edge.
    task automatic cycle(input bit v, input logic [15:0] d, input bit p);
        bit full, empty;
        valid_i = v; data_i = d; pop_req_i = p;
        @(posedge clk);
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (v && full) m_ovf = 1;
        if (p && empty) m_unf = 1;
        if (p && !empty) void'(mq.pop_front());
        if (v && !full) mq.push_back(d);
        #1;
        valid_i = 0; pop_req_i = 0;
    endtask

    task automatic apply_reset();
        rst = 1; valid_i = 0; pop_req_i = 0;
        @(posedge clk); #1;
        rst = 0;
        mq.delete(); m_ovf = 0; m_unf = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if ({ovf_err_o, unf_err_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ovf_err_o, unf_err_o); end
        checks++; if (q_o !== 16'h0) begin errors++; $display("FAIL reset_q got=%h exp=0000", q_o); end
        checks++; if (route_o !== 3'd0) begin errors++; $display("FAIL reset_route got=%0d exp=0", route_o); end
        apply_reset();
    endtask

    task automatic test_route();
        logic [15:0] flits [6] = '{16'h3000, 16'h0000, 16'h4000, 16'h6000, 16'h5000, 16'h8000};
        int          exp_r [6] = '{3, 3, 1, 0, 4, 2};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1, flits[i], 0);
            checks++; if (route_o !== 3'(exp_r[i])) begin errors++; $display("FAIL route_%0d got=%0d exp=%0d", i, route_o, exp_r[i]); end
            checks++; if (q_o !== flits[i]) begin errors++; $display("FAIL route_q_%0d got=%h exp=%h", i, q_o, flits[i]); end
            cycle(0, 16'h0, 1);
        end
    endtask

    task automatic test_fill();
        logic [15:0] d;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            d = 16'($urandom);
            cycle(1, d, 0);
        end
        checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", ready_o); end
        cycle(1, 16'hDEAD, 0);
        checks++; if (ovf_err_o !== 1'b1) begin errors++; $display("FAIL fill_ovf got=%b exp=1", ovf_err_o); end
        checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL fill_drop_count got=%0d exp=4", count_o); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (q_o !== mq[0]) begin errors++; $display("FAIL fill_order_%0d got=%h exp=%h", i, q_o, mq[0]); end
            cycle(0, 16'h0, 1);
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL fill_empty_valid got=%b exp=0", valid_o); end
        checks++; if (ovf_err_o !== 1'b1) begin errors++; $display("FAIL fill_ovf_sticky got=%b exp=1", ovf_err_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        cycle(1, 16'($urandom), 0);
        cycle(1, 16'($urandom), 0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (q_o !== mq[0]) begin errors++; $display("FAIL b2b_q_%0d got=%h exp=%h", i, q_o, mq[0]); end
            cycle(1, 16'($urandom), 1);
            checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL b2b_count_%0d got=%0d exp=2", i, count_o); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (q_o !== mq[0]) begin errors++; $display("FAIL b2b_drain_%0d got=%h exp=%h", i, q_o, mq[0]); end
            cycle(0, 16'h0, 1);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        cycle(1, 16'h1234, 1);
        checks++; if (unf_err_o !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", unf_err_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL unf_valid got=%b exp=1", valid_o); end
        checks++; if (q_o !== 16'h1234) begin errors++; $display("FAIL unf_q got=%h exp=1234", q_o); end
        checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL unf_count got=%0d exp=1", count_o); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        cycle(0, 16'h0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 16'($urandom), 0);
        #3 rst = 1;
        #1;
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", count_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", valid_o); end
        checks++; if ({ovf_err_o, unf_err_o} !== 2'b00) begin errors++; $display("FAIL arst_flags got=%b%b exp=00", ovf_err_o, unf_err_o); end
        @(negedge clk); rst = 0;
        mq.delete(); m_ovf = 0; m_unf = 0;
        cycle(1, 16'hBEEF, 0);
        checks++; if (valid_o !== 1'b1 || q_o !== 16'hBEEF) begin errors++; $display("FAIL arst_resume got=%b/%h exp=1/beef", valid_o, q_o); end
        checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL arst_resume_count got=%0d exp=1", count_o); end
    endtask

    task automatic test_random();
        bit v, p;
        apply_reset();
        for (int i = 0; i < 10000; i++) begin
            v = ($urandom_range(0, 99) < 55);
            p = ($urandom_range(0, 99) < 50);
            cycle(v, 16'($urandom), p);
            checks++; if (count_o !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", i, count_o, mq.size()); end
            checks++; if (valid_o !== (mq.size() != 0) || ready_o !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_hs c%0d got=%b%b exp=%b%b", i, valid_o, ready_o, mq.size() != 0, mq.size() != DEPTH); end
            checks++; if (ovf_err_o !== m_ovf || unf_err_o !== m_unf) begin errors++; $display("FAIL rnd_flags c%0d got=%b%b exp=%b%b", i, ovf_err_o, unf_err_o, m_ovf, m_unf); end
            if (mq.size() != 0) begin
                checks++; if (q_o !== mq[0] || route_o !== 3'(ref_route(mq[0]))) begin errors++; $display("FAIL rnd_head c%0d got=%h/%0d exp=%h/%0d", i, q_o, route_o, mq[0], ref_route(mq[0])); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_route();
        test_fill();
        test_back_to_back();
        test_underflow();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
